// File: rtl/multimode_dac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_pkg
// Brief    : Mode encodings, integrator width helpers and saturating add for
//            the multimode single-bit DAC.
// Revision : 1.0 - initial release
// ============================================================================
package dac_pkg;

    localparam logic [1:0] MODE_PWM  = 2'b00;
    localparam logic [1:0] MODE_SD1  = 2'b01;
    localparam logic [1:0] MODE_SD2  = 2'b10;
    localparam logic [1:0] MODE_MUTE = 2'b11;

    function automatic int i1_width(input int w);
        return w + 2;
    endfunction

    function automatic int i2_width(input int w);
        return w + 4;
    endfunction

    // a + b clamped to the signed range of a w-bit destination (w <= 31)
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = a + b;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic logic sat_hit(input logic signed [31:0] a,
                                     input logic signed [31:0] b,
                                     input int w);
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = a + b;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return (s > hi) || (s < lo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multimode_dac_if.sv
`default_nettype none
// ============================================================================
// Module   : multimode_dac_if
// Brief    : Sample pull interface between the sample source and the DAC.
// Revision : 1.0 - initial release
// ============================================================================
interface multimode_dac_if #(
    parameter int WIDTH = 8
);
    logic [1:0]              mode;
    logic signed [WIDTH-1:0] din;
    logic                    din_ack;

    modport master (output mode, output din, input  din_ack);
    modport slave  (input  mode, input  din, output din_ack);
endinterface
`default_nettype wire

// File: rtl/multimode_dac_sd2_loop.sv
`default_nettype none
// ============================================================================
// Module   : sd2_loop
// Brief    : Second-order sigma-delta integrators with saturation and ovf flag.
// Revision : 1.0 - initial release
// ============================================================================
module sd2_loop
    import dac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire                     clk,
    input  wire                     rst_an,
    input  wire                     i_en,
    input  wire                     i_clr,
    input  wire signed [WIDTH-1:0]  i_data,
    input  wire                     i_fb,
    output logic                    o_bit,
    output logic                    o_ovf
);
    localparam int                 c_i1_w = i1_width(WIDTH);
    localparam int                 c_i2_w = i2_width(WIDTH);
    localparam logic signed [31:0] c_fs   = 32'sd1 <<< (WIDTH - 1);

    logic signed [c_i1_w-1:0] r_i1;
    logic signed [c_i1_w-1:0] w_i1_next;
    logic signed [c_i2_w-1:0] r_i2;
    logic signed [c_i2_w-1:0] w_i2_next;
    logic signed [31:0]       w_y;
    logic                     w_hit;
    logic                     r_ovf;

    // Both integrators see the feedback of the bit currently on the pin; i2 uses the old i1
    always_comb begin
        w_y       = i_fb ? c_fs : -c_fs;
        w_i1_next = c_i1_w'(sat_add(32'(r_i1), 32'(i_data) - w_y, c_i1_w));
        w_i2_next = c_i2_w'(sat_add(32'(r_i2), 32'(r_i1) - w_y, c_i2_w));
        w_hit     = sat_hit(32'(r_i1), 32'(i_data) - w_y, c_i1_w)
                  | sat_hit(32'(r_i2), 32'(r_i1) - w_y, c_i2_w);
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            r_i1  <= '0;
            r_i2  <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_i1  <= '0;
            r_i2  <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= i_en & w_hit;
            if (i_en) begin
                r_i1 <= w_i1_next;
                r_i2 <= w_i2_next;
            end
        end
    end

    assign o_bit = ~w_i2_next[c_i2_w-1];
    assign o_ovf = r_ovf;
endmodule
`default_nettype wire

// File: rtl/multimode_dac.sv
`default_nettype none
// ============================================================================
// Module   : multimode_dac
// Brief    : Single-bit audio DAC with PWM, SD1, SD2 and mute modes.
// Revision : 1.0 - initial release
// ============================================================================
module multimode_dac
    import dac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire             clk,
    input  wire             rst_an,
    multimode_dac_if.slave  bus,
    output logic            dacout,
    output logic            ovf
);
    logic [WIDTH-1:0]        r_cnt;
    logic [WIDTH-1:0]        r_acc;
    logic signed [WIDTH-1:0] r_data;
    logic [1:0]              r_mode_q;
    logic                    r_ack;
    logic                    r_dacout;
    logic [WIDTH-1:0]        w_u;
    logic [WIDTH:0]          w_s;
    logic                    w_boundary;
    logic                    w_clr;
    logic                    w_sd2_en;
    logic                    w_sd2_bit;
    logic                    w_dac_next;

    assign w_boundary = (r_cnt == '1);
    assign w_clr      = w_boundary && (bus.mode != r_mode_q);
    assign w_sd2_en   = (r_mode_q == MODE_SD2);
    assign w_u        = {~r_data[WIDTH-1], r_data[WIDTH-2:0]};
    assign w_s        = {1'b0, r_acc} + {1'b0, w_u};

    sd2_loop #(.WIDTH(WIDTH)) u_sd2 (
        .clk    (clk),
        .rst_an (rst_an),
        .i_en   (w_sd2_en),
        .i_clr  (w_clr),
        .i_data (r_data),
        .i_fb   (r_dacout),
        .o_bit  (w_sd2_bit),
        .o_ovf  (ovf)
    );

    // Output follows the mode in force before this edge; a newly latched mode shows one edge later
    always_comb begin
        w_dac_next = 1'b0;
        case (r_mode_q)
            MODE_PWM: w_dac_next = (w_u > r_cnt);
            MODE_SD1: w_dac_next = w_s[WIDTH];
            MODE_SD2: w_dac_next = w_sd2_bit;
            default:  w_dac_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_data   <= '0;
            r_mode_q <= MODE_PWM;
            r_ack    <= 1'b0;
            r_dacout <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_ack    <= w_boundary;
            r_dacout <= w_dac_next;
            if (w_boundary) begin
                r_data   <= bus.din;
                r_mode_q <= bus.mode;
            end
            if (w_clr) begin
                r_acc <= '0;
            end else if (r_mode_q == MODE_SD1) begin
                r_acc <= w_s[WIDTH-1:0];
            end
        end
    end

    assign bus.din_ack = r_ack;
    assign dacout      = r_dacout;
endmodule
`default_nettype wire

// File: tb/tb_multimode_dac.sv
`default_nettype none
// ============================================================================
// Module   : tb_multimode_dac
// Brief    : Directed self-checking bench for multimode_dac at WIDTH = 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multimode_dac;
    import dac_pkg::*;

    localparam int c_width = 8;

    logic clk    = 1'b0;
    logic rst_an = 1'b1;
    logic dacout;
    logic ovf;

    int n_checks = 0;
    int n_errors = 0;
    int n, ones, ovfs, first_one, last_one;
    int ovf_acc;

    multimode_dac_if #(.WIDTH(c_width)) bus ();

    multimode_dac #(.WIDTH(c_width)) dut (
        .clk    (clk),
        .rst_an (rst_an),
        .bus    (bus),
        .dacout (dacout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run until the next ack, gathering the window's ones/ovf statistics
    task automatic period();
        n = 0; ones = 0; ovfs = 0; first_one = 0; last_one = 0;
        do begin
            step();
            n++;
            if (dacout) begin
                ones++;
                if (first_one == 0) first_one = n;
                last_one = n;
            end
            if (ovf) ovfs++;
        end while (!bus.din_ack && n < 600);
    endtask

    initial begin
        bus.mode = MODE_PWM;
        bus.din  = 8'sh80;
        #2 rst_an = 1'b0;
        step();
        step();
        check("rst_dacout",  int'(dacout),      0);
        check("rst_din_ack", int'(bus.din_ack), 0);
        check("rst_ovf",     int'(ovf),         0);
        rst_an = 1'b1;

        period();
        check("first_ack", n, 256);
        bus.din = 8'sh00;

        period();
        check("ack_spacing", n, 256);
        check("pwm_m128_ones", ones, 0);
        bus.din = 8'sh7f;

        period();
        check("pwm_0_ones", ones, 128);
        check("pwm_0_first", first_one, 1);
        check("pwm_0_last", last_one, 128);
        bus.mode = MODE_SD1;
        bus.din  = 8'sh40;

        period();
        check("pwm_127_ones", ones, 255);
        period();
        check("sd1_64_ones_a", ones, 192);
        bus.din = 8'sh80;
        period();
        check("sd1_64_ones_b", ones, 192);
        bus.mode = MODE_SD2;
        bus.din  = 8'sh20;
        period();
        check("sd1_m128_ones", ones, 0);

        ovf_acc = 0;
        repeat (4) begin
            period();
            ovf_acc += ovfs;
        end
        period();
        ovf_acc += ovfs;
        check($sformatf("sd2_32_density_ones=%0d", ones), int'(ones >= 158 && ones <= 162), 1);
        check("sd2_32_ovf_count", ovf_acc, 0);

        // Mode input moved mid-period must wait for the next boundary
        repeat (100) step();
        bus.mode = MODE_SD1;
        bus.din  = 8'sh40;
        step();
        check("mid_mode_q_held", int'(dut.r_mode_q), int'(MODE_SD2));
        period();
        check("mid_remaining", n, 155);
        check("mid_mode_q_new", int'(dut.r_mode_q), int'(MODE_SD1));
        check("mid_i1_cleared", int'(dut.u_sd2.r_i1), 0);
        check("mid_i2_cleared", int'(dut.u_sd2.r_i2), 0);
        bus.mode = MODE_MUTE;

        period();
        check("sd1_after_switch", ones, 192);
        bus.mode = MODE_SD2;
        bus.din  = 8'sh7f;
        period();
        check("mute_ones", ones, 0);
        check("mute_ack_spacing", n, 256);
        check("mute_ovf", ovfs, 0);

        ovf_acc = 0;
        period();
        ovf_acc += ovfs;
        period();
        ovf_acc += ovfs;
        period();
        ovf_acc += ovfs;
        check($sformatf("sd2_127_ovf_seen_count=%0d", ovf_acc), int'(ovf_acc > 0), 1);
        check($sformatf("sd2_127_density_ones=%0d", ones), int'(ones >= 244), 1);

        // Asynchronous reset at cnt = 100
        repeat (100) step();
        check("pre_rst_cnt", int'(dut.r_cnt), 100);
        rst_an = 1'b0;
        #1;
        check("async_rst_dacout",  int'(dacout),      0);
        check("async_rst_din_ack", int'(bus.din_ack), 0);
        check("async_rst_ovf",     int'(ovf),         0);
        step();
        step();
        rst_an = 1'b1;
        period();
        check("ack_after_rst", n, 256);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
